// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants for the round-robin decode arbiter
package rr_arb_pkg;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Default sizing
  localparam int NUM_REQ_DEF  = 4;
  localparam int MAX_HOLD_DEF = 16;

endpackage

// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - enable-gated index to one-hot decoder
module grant_decoder
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int SEL_W   = 2
) (
  input  logic [SEL_W-1:0]   idx,
  input  logic               en,
  output logic [NUM_REQ-1:0] onehot
);

  // One bit set at idx while enabled, all zero otherwise
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter with held grant, timeout and one-hot select
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int SEL_W    = 2,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic               done_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [SEL_W-1:0]   grant_idx_out,
  output logic               enable_out,
  output logic               timeout_out
);

  localparam int                CNT_W    = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [SEL_W-1:0]  LAST_RST = SEL_W'(NUM_REQ - 1);

  logic [1:0]         state, state_d;
  logic [SEL_W-1:0]   last_idx, last_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [SEL_W-1:0]   idx_d;
  logic               en_d;
  logic               tmo_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [SEL_W-1:0]   winner;
  logic               owner_release;
  logic               at_max;

  // First requester at or after last+1, wrapping; the index arithmetic wraps naturally
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                input logic [SEL_W-1:0]   last);
    logic [SEL_W-1:0] cand;
    logic             found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!found && req[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner        = rr_pick(req_in, last_idx);
  assign owner_release = done_in || !req_in[grant_idx_out];
  assign at_max        = (cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state: arbitrate in IDLE, release or time out in GRANT, single GAP cycle
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (|req_in) state_d = ST_GRANT;
      ST_GRANT: if (owner_release || at_max) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; a release beats a coincident timeout
  always_comb begin
    idx_d  = grant_idx_out;
    last_d = last_idx;
    cnt_d  = cnt;
    en_d   = 1'b0;
    tmo_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req_in) begin
          idx_d  = winner;
          last_d = winner;
          cnt_d  = '0;
          en_d   = 1'b1;
        end
      end
      ST_GRANT: begin
        if (owner_release) begin
          en_d = 1'b0;
        end else if (at_max) begin
          tmo_d = 1'b1;
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  grant_decoder #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_grant_decoder (
    .idx    (idx_d),
    .en     (en_d),
    .onehot (grant_d)
  );

  // Output, pointer and hold-counter registers
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      grant_out     <= '0;
      grant_idx_out <= '0;
      enable_out    <= 1'b0;
      timeout_out   <= 1'b0;
      last_idx      <= LAST_RST;
      cnt           <= '0;
    end else begin
      grant_out     <= grant_d;
      grant_idx_out <= idx_d;
      enable_out    <= en_d;
      timeout_out   <= tmo_d;
      last_idx      <= last_d;
      cnt           <= cnt_d;
    end
  end

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 16;

  localparam int P_IDLE  = 0;
  localparam int P_GRANT = 1;
  localparam int P_GAP   = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [1:0]   idx;
  logic         en;
  logic         tmo;

  int checks = 0;
  int errors = 0;

  // reference model: phase, owner, last winner, cycles of enable already elapsed
  int           m_phase;
  int           m_owner;
  int           m_last;
  int           m_held;
  logic         m_tmo;
  logic [N-1:0] e_grant;
  logic [1:0]   e_idx;
  logic         e_en;
  logic         e_tmo;

  rr_decode_arbiter #(
    .NUM_REQ  (N),
    .SEL_W    (2),
    .MAX_HOLD (HOLD)
  ) dut (
    .clk_in        (clk),
    .reset_in      (rst),
    .req_in        (req),
    .done_in       (done),
    .grant_out     (grant),
    .grant_idx_out (idx),
    .enable_out    (en),
    .timeout_out   (tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_outputs();
    e_en    = (m_phase == P_GRANT);
    e_grant = e_en ? (N'(1) << m_owner) : '0;
    e_idx   = 2'(m_owner);
    e_tmo   = m_tmo;
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_owner = 0;
    m_last  = N - 1;
    m_held  = 0;
    m_tmo   = 1'b0;
    model_outputs();
  endtask

  task automatic model_step();
    int c;
    bit found;
    m_tmo = 1'b0;
    case (m_phase)
      P_IDLE: begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found   = 1;
            m_owner = c;
            m_last  = c;
          end
        end
        if (found) begin
          m_phase = P_GRANT;
          m_held  = 1;
        end
      end
      P_GRANT: begin
        if (done || !req[m_owner]) begin
          m_phase = P_GAP;
        end else if (m_held == HOLD) begin
          m_phase = P_GAP;
          m_tmo   = 1'b1;
        end else begin
          m_held = m_held + 1;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    model_outputs();
  endtask

  // one clock edge; model sees the same inputs the DUT sampled, outputs settle 1ns later
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: grant=%b idx=%0d en=%b tmo=%b required 0000/0/0/0", grant, idx, en, tmo);
    end
    tick();
    checks++;
    if ({grant, en} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL idle_no_req: grant=%b en=%b required 0000/0", grant, en);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_grant: grant=%b idx=%0d en=%b tmo=%b required 0001/0/1/0", grant, idx, en, tmo);
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    foreach (order[i]) begin
      tick();
      checks++;
      if ({grant, idx, en} !== {4'(1 << order[i]), 2'(order[i]), 1'b1}) begin
        errors++;
        $display("FAIL rr_grant_%0d: grant=%b idx=%0d en=%b required %b/%0d/1",
                 i, grant, idx, en, 4'(1 << order[i]), order[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if ({grant, idx, en, tmo} !== {4'b0000, 2'(order[i]), 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL rr_gap_%0d: grant=%b idx=%0d en=%b tmo=%b required 0000/%0d/0/0",
                 i, grant, idx, en, tmo, order[i]);
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    int high;
    do_reset();
    req = 4'b0100;
    tick();
    high = 0;
    for (int c = 0; c < 40 && en === 1'b1; c++) begin
      high++;
      checks++;
      if (tmo !== 1'b0 || grant !== 4'b0100) begin
        errors++;
        $display("FAIL hold_cycle_%0d: grant=%b tmo=%b required 0100/0", c, grant, tmo);
      end
      tick();
    end
    checks++;
    if (high != HOLD) begin
      errors++;
      $display("FAIL hold_length: enable cycles=%0d required %0d", high, HOLD);
    end
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0000, 2'd2, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_pulse: grant=%b idx=%0d en=%b tmo=%b required 0000/2/0/1", grant, idx, en, tmo);
    end
    tick();
    checks++;
    if ({en, tmo} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_single: en=%b tmo=%b required 0/0", en, tmo);
    end
    tick();
    checks++;
    if ({grant, idx, en} !== {4'b0100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL regrant_2: grant=%b idx=%0d en=%b required 0100/2/1", grant, idx, en);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    tick();
    checks++;
    if ({grant, idx, en} !== {4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_hold: grant=%b idx=%0d en=%b required 0010/1/1", grant, idx, en);
    end
    req = 4'b1000;
    tick();
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0000, 2'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL withdraw_gap: grant=%b idx=%0d en=%b tmo=%b required 0000/1/0/0", grant, idx, en, tmo);
    end
    tick();
    tick();
    checks++;
    if ({grant, idx, en} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL withdraw_next: grant=%b idx=%0d en=%b required 1000/3/1", grant, idx, en);
    end
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    req = 4'b0001;
    tick();
    repeat (HOLD - 1) tick();
    checks++;
    if (en !== 1'b1) begin
      errors++;
      $display("FAIL done_race_pre: en=%b required 1", en);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if ({grant, en, tmo} !== {4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL done_beats_timeout: grant=%b en=%b tmo=%b required 0000/0/0", grant, en, tmo);
    end
    tick();
    checks++;
    if (tmo !== 1'b0) begin
      errors++;
      $display("FAIL done_race_post: tmo=%b required 0", tmo);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0000, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: grant=%b idx=%0d en=%b tmo=%b required 0000/0/0/0", grant, idx, en, tmo);
    end
    tick();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    checks++;
    if ({grant, idx, en, tmo} !== {4'b0001, 2'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL post_reset_grant: grant=%b idx=%0d en=%b tmo=%b required 0001/0/1/0", grant, idx, en, tmo);
    end
  endtask

  task automatic test_random();
    int quiet;
    do_reset();
    quiet = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c % 60 == 0) quiet = $urandom_range(0, 1);
      if ($urandom_range(0, quiet ? 40 : 4) == 0) req = 4'($urandom);
      done = quiet ? 1'b0 : ($urandom_range(0, 4) == 0);
      tick();
      checks++;
      if ({grant, idx, en, tmo} !== {e_grant, e_idx, e_en, e_tmo}) begin
        errors++;
        $display("FAIL random_cycle_%0d: grant=%b idx=%0d en=%b tmo=%b required %b/%0d/%b/%b",
                 c, grant, idx, en, tmo, e_grant, e_idx, e_en, e_tmo);
      end
      checks++;
      if (((grant & (grant - 4'd1)) != 4'd0) || ((grant != 4'd0) !== en)) begin
        errors++;
        $display("FAIL onehot_invariant_%0d: grant=%b en=%b required one-hot iff enabled", c, grant, en);
      end
    end
    req  = '0;
    done = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_done_at_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
